// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU request arbiter.
package alu_arb_pkg;

   localparam int unsigned ARB_NREQ    = 4;
   localparam int unsigned ARB_IDX_W   = 2;
   localparam int unsigned ARB_TIMEOUT = 51;
   localparam int unsigned OP_W        = 4;
   localparam int unsigned DATA_W      = 32;
   localparam int unsigned BASE_W      = 2;
   localparam int unsigned CNT_W       = 8;
   localparam int unsigned OPCNT_W     = 32;
   localparam int unsigned TOCNT_W     = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } arb_state_e;

   typedef enum logic [BASE_W-1:0] {
      BASE_2    = 2'd0,
      BASE_10   = 2'd1,
      BASE_12   = 2'd2,
      BASE_RSVD = 2'd3
   } base_sel_e;

   // Operation captured at grant and driven to the router.
   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [BASE_W-1:0] base;
   } alu_req_t;

   // Reserved base encoding is treated as base-12.
   function automatic logic [BASE_W-1:0] map_base(input logic [BASE_W-1:0] b);
      return (b == BASE_RSVD) ? BASE_W'(BASE_12) : b;
   endfunction

   function automatic logic [ARB_NREQ-1:0] idx_to_onehot(input logic [ARB_IDX_W-1:0] idx);
      return ARB_NREQ'(1) << idx;
   endfunction

endpackage

// File: rtl/alu_request_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_picker
   import alu_arb_pkg::*;
(
   input  logic [ARB_NREQ-1:0]  req,
   input  logic [ARB_IDX_W-1:0] last_grant,
   output logic [ARB_NREQ-1:0]  sel_c,
   output logic [ARB_IDX_W-1:0] sel_idx_c,
   output logic                 sel_valid_c
);

   logic [ARB_IDX_W-1:0] cand;

   // Scan last_grant+1 .. last_grant+NREQ; the index wraps naturally in ARB_IDX_W bits.
   always_comb begin
      sel_c       = '0;
      sel_idx_c   = '0;
      sel_valid_c = 1'b0;
      cand        = '0;
      for (int unsigned k = 1; k <= ARB_NREQ; k++) begin
         cand = last_grant + ARB_IDX_W'(k);
         if (!sel_valid_c && req[cand]) begin
            sel_valid_c = 1'b1;
            sel_idx_c   = cand;
            sel_c       = idx_to_onehot(cand);
         end
      end
   end

endmodule

// File: rtl/alu_request_arbiter.sv
// Round-robin arbiter sharing one ALU router among four requesters.
module alu_request_arbiter
   import alu_arb_pkg::*;
#(
   parameter int unsigned NREQ    = ARB_NREQ,
   parameter int unsigned TIMEOUT = ARB_TIMEOUT
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*OP_W-1:0]     req_op,
   input  logic [NREQ*DATA_W-1:0]   req_a,
   input  logic [NREQ*DATA_W-1:0]   req_b,
   input  logic [NREQ*BASE_W-1:0]   req_base,
   output logic [NREQ-1:0]          grant,
   output logic [NREQ-1:0]          rsp_valid,
   output logic [DATA_W-1:0]        rsp_result,
   output logic                     rsp_timeout,
   output logic [OP_W-1:0]          rt_operation,
   output logic [DATA_W-1:0]        rt_operand_a,
   output logic [DATA_W-1:0]        rt_operand_b,
   output logic [BASE_W-1:0]        rt_base_select,
   input  logic [DATA_W-1:0]        rt_result,
   input  logic                     rt_done,
   output logic                     busy,
   output logic [OPCNT_W-1:0]       op_count,
   output logic [TOCNT_W-1:0]       timeout_count
);

   arb_state_e           state;
   logic [ARB_IDX_W-1:0] last_grant;
   logic [CNT_W-1:0]     wait_cnt;
   alu_req_t             cap;

   logic [ARB_NREQ-1:0]  pick_c;
   logic [ARB_IDX_W-1:0] pick_idx_c;
   logic                 pick_valid_c;

   rr_picker u_picker (
      .req         (ARB_NREQ'(req)),
      .last_grant  (last_grant),
      .sel_c       (pick_c),
      .sel_idx_c   (pick_idx_c),
      .sel_valid_c (pick_valid_c)
   );

   assign rt_operation   = cap.op;
   assign rt_operand_a   = cap.a;
   assign rt_operand_b   = cap.b;
   assign rt_base_select = cap.base;

   // Arbitration, capture, router wait and response generation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         last_grant    <= ARB_IDX_W'(ARB_NREQ - 1);
         wait_cnt      <= '0;
         cap           <= '0;
         grant         <= '0;
         rsp_valid     <= '0;
         rsp_result    <= '0;
         rsp_timeout   <= 1'b0;
         busy          <= 1'b0;
         op_count      <= '0;
         timeout_count <= '0;
      end else begin
         grant       <= '0;
         rsp_valid   <= '0;
         rsp_timeout <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pick_valid_c) begin
                  grant      <= NREQ'(pick_c);
                  last_grant <= pick_idx_c;
                  cap.op     <= req_op[{pick_idx_c, 2'b00} +: OP_W];
                  cap.a      <= req_a[{pick_idx_c, 5'b00000} +: DATA_W];
                  cap.b      <= req_b[{pick_idx_c, 5'b00000} +: DATA_W];
                  cap.base   <= map_base(req_base[{pick_idx_c, 1'b0} +: BASE_W]);
                  wait_cnt   <= '0;
                  busy       <= 1'b1;
                  state      <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               wait_cnt <= wait_cnt + CNT_W'(1);
               // First WAIT cycle is the router settle cycle; done is not trusted there.
               if (rt_done && (wait_cnt != '0)) begin
                  rsp_valid  <= NREQ'(idx_to_onehot(last_grant));
                  rsp_result <= rt_result;
                  op_count   <= op_count + OPCNT_W'(1);
                  busy       <= 1'b0;
                  state      <= ST_IDLE;
               end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
                  rsp_valid   <= NREQ'(idx_to_onehot(last_grant));
                  rsp_result  <= '0;
                  rsp_timeout <= 1'b1;
                  op_count    <= op_count + OPCNT_W'(1);
                  if (timeout_count != '1) begin
                     timeout_count <= timeout_count + TOCNT_W'(1);
                  end
                  busy        <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_request_arbiter.sv
// Self-checking bench: directed vector table, reset corner case, random transactions.
module tb_alu_request_arbiter;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [3:0]    req = '0;
   logic [15:0]   req_op = '0;
   logic [127:0]  req_a = '0;
   logic [127:0]  req_b = '0;
   logic [7:0]    req_base = '0;
   logic [3:0]    grant;
   logic [3:0]    rsp_valid;
   logic [31:0]   rsp_result;
   logic          rsp_timeout;
   logic [3:0]    rt_operation;
   logic [31:0]   rt_operand_a;
   logic [31:0]   rt_operand_b;
   logic [1:0]    rt_base_select;
   logic [31:0]   rt_result = '0;
   logic          rt_done = 1'b0;
   logic          busy;
   logic [31:0]   op_count;
   logic [15:0]   timeout_count;

   always #5 clk = ~clk;

   alu_request_arbiter #(.NREQ(4), .TIMEOUT(51)) dut (
      .clk            (clk),
      .reset          (reset),
      .req            (req),
      .req_op         (req_op),
      .req_a          (req_a),
      .req_b          (req_b),
      .req_base       (req_base),
      .grant          (grant),
      .rsp_valid      (rsp_valid),
      .rsp_result     (rsp_result),
      .rsp_timeout    (rsp_timeout),
      .rt_operation   (rt_operation),
      .rt_operand_a   (rt_operand_a),
      .rt_operand_b   (rt_operand_b),
      .rt_base_select (rt_base_select),
      .rt_result      (rt_result),
      .rt_done        (rt_done),
      .busy           (busy),
      .op_count       (op_count),
      .timeout_count  (timeout_count)
   );

   int n_chk = 0;
   int n_fail = 0;

   // Reference model state: last served requester and expected counters.
   int m_last = 3;
   int m_ops  = 0;
   int m_tos  = 0;

   typedef struct {
      bit          rst;
      logic [3:0]  mask;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  base;
      int          d;
      logic [31:0] res;
      bit          hold;
      int          idle;
      int          exp_idx;
      int          exp_r;
      bit          exp_to;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply_reset();
      reset    = 1'b1;
      req      = '0;
      rt_done  = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_result", rsp_result, 32'h0);
      chk("rst_rsp_timeout", 32'(rsp_timeout), 32'h0);
      chk("rst_rt_operation", 32'(rt_operation), 32'h0);
      chk("rst_rt_operand_a", rt_operand_a, 32'h0);
      chk("rst_rt_operand_b", rt_operand_b, 32'h0);
      chk("rst_rt_base", 32'(rt_base_select), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_op_count", op_count, 32'h0);
      chk("rst_timeout_count", 32'(timeout_count), 32'h0);
      reset  = 1'b0;
      m_last = 3;
      m_ops  = 0;
      m_tos  = 0;
   endtask

   // One transaction, entered and left at a negedge inside an IDLE cycle.
   // Router raises done from WAIT cycle d onward; exp_r is the cycle index the response is seen.
   task automatic run_txn(input logic [3:0] mask, input logic [15:0] ops,
                          input logic [127:0] a, input logic [127:0] b, input logic [7:0] base,
                          input int d, input logic [31:0] res, input bit hold, input int idle,
                          input int exp_idx, input int exp_r, input bit exp_to);
      logic [3:0]  exp_oh;
      logic [3:0]  eop;
      logic [31:0] ea;
      logic [31:0] eb;
      logic [1:0]  ebase;
      exp_oh = 4'b0001 << exp_idx;
      eop    = ops[exp_idx*4 +: 4];
      ea     = a[exp_idx*32 +: 32];
      eb     = b[exp_idx*32 +: 32];
      ebase  = base[exp_idx*2 +: 2];
      if (ebase == 2'd3) ebase = 2'd2;
      for (int i = 0; i < idle; i++) begin
         req = '0;
         @(negedge clk);
         chk("idle_grant", 32'(grant), 32'h0);
         chk("idle_busy", 32'(busy), 32'h0);
      end
      req      = mask;
      req_op   = ops;
      req_a    = a;
      req_b    = b;
      req_base = base;
      @(negedge clk);
      chk("grant", 32'(grant), 32'(exp_oh));
      chk("rt_operation", 32'(rt_operation), 32'(eop));
      chk("rt_operand_a", rt_operand_a, ea);
      chk("rt_operand_b", rt_operand_b, eb);
      chk("rt_base_select", 32'(rt_base_select), 32'(ebase));
      chk("busy_wait", 32'(busy), 32'h1);
      chk("rsp_at_grant", 32'(rsp_valid), 32'h0);
      m_last = exp_idx;
      // Requests and operands churn while the operation is in flight.
      req       = 4'($urandom);
      req_op    = {$urandom, $urandom} [15:0];
      req_a     = {$urandom, $urandom, $urandom, $urandom};
      req_b     = {$urandom, $urandom, $urandom, $urandom};
      req_base  = 8'($urandom);
      rt_result = res;
      rt_done   = (d <= 0);
      for (int j = 1; j < exp_r; j++) begin
         @(negedge clk);
         chk("no_early_rsp", 32'(rsp_valid), 32'h0);
         chk("no_wait_grant", 32'(grant), 32'h0);
         chk("no_wait_timeout", 32'(rsp_timeout), 32'h0);
         rt_done = (j >= d);
      end
      @(negedge clk);
      m_ops++;
      if (exp_to) m_tos++;
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_oh));
      chk("rsp_result", rsp_result, exp_to ? 32'h0 : res);
      chk("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
      chk("op_count", op_count, 32'(m_ops));
      chk("timeout_count", 32'(timeout_count), 32'(m_tos));
      chk("rsp_grant", 32'(grant), 32'h0);
      chk("rsp_busy", 32'(busy), 32'h0);
      req     = '0;
      rt_done = hold;
   endtask

   // Spread a row's operands so each requester presents distinct values.
   task automatic run_vec(input vec_t v);
      logic [15:0]  ops;
      logic [127:0] a;
      logic [127:0] b;
      logic [7:0]   base;
      for (int i = 0; i < 4; i++) begin
         ops[i*4 +: 4]  = 4'((int'(v.op) + i) % 9);
         a[i*32 +: 32]  = v.a + 32'(i) * 32'h1000_0000;
         b[i*32 +: 32]  = v.b + 32'(i) * 32'h0100_0000;
         base[i*2 +: 2] = v.base;
      end
      if (v.rst) apply_reset();
      run_txn(v.mask, ops, a, b, base, v.d, v.res, v.hold, v.idle, v.exp_idx, v.exp_r, v.exp_to);
   endtask

   task automatic run_random(input int n);
      logic [3:0]   mask;
      logic [15:0]  ops;
      logic [127:0] a;
      logic [127:0] b;
      logic [7:0]   base;
      int d, dd, r, idx, idle;
      bit to;
      for (int t = 0; t < n; t++) begin
         mask = 4'($urandom_range(1, 15));
         for (int i = 0; i < 4; i++) begin
            ops[i*4 +: 4]  = 4'($urandom_range(0, 8));
            a[i*32 +: 32]  = $urandom;
            b[i*32 +: 32]  = $urandom;
            base[i*2 +: 2] = 2'($urandom_range(0, 3));
         end
         d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(45, 70)) : int'($urandom_range(0, 8));
         dd = (d < 1) ? 1 : d;
         to = (dd > 51);
         r  = to ? 52 : dd + 1;
         idx = -1;
         for (int k = 1; k <= 4; k++) begin
            if (idx < 0 && mask[(m_last + k) % 4]) idx = (m_last + k) % 4;
         end
         idle = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         run_txn(mask, ops, a, b, base, d, $urandom, 1'($urandom), idle, idx, r, to);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //           rst mask     op    a             b             base  d   res           hold idle idx r   to
      vecs.push_back('{1, 4'b0001, 4'd0, 32'h0000_1234, 32'h0000_5678, 2'd0, 3,  32'h0000_68AC, 0, 1, 0, 4,  0});
      vecs.push_back('{1, 4'b1111, 4'd1, 32'h0000_0A00, 32'h0000_0B00, 2'd1, 2,  32'h0000_0011, 0, 0, 0, 3,  0});
      vecs.push_back('{0, 4'b1111, 4'd2, 32'h0000_0A01, 32'h0000_0B01, 2'd1, 2,  32'h0000_0022, 0, 0, 1, 3,  0});
      vecs.push_back('{0, 4'b1111, 4'd3, 32'h0000_0A02, 32'h0000_0B02, 2'd2, 2,  32'h0000_0033, 0, 0, 2, 3,  0});
      vecs.push_back('{0, 4'b1111, 4'd4, 32'h0000_0A03, 32'h0000_0B03, 2'd0, 2,  32'h0000_0044, 0, 0, 3, 3,  0});
      vecs.push_back('{0, 4'b1111, 4'd5, 32'h0000_0A04, 32'h0000_0B04, 2'd1, 2,  32'h0000_0055, 0, 0, 0, 3,  0});
      vecs.push_back('{0, 4'b0010, 4'd6, 32'h1111_0000, 32'h2222_0000, 2'd0, 5,  32'h0000_0066, 0, 0, 1, 6,  0});
      vecs.push_back('{0, 4'b0101, 4'd7, 32'h3333_0000, 32'h4444_0000, 2'd2, 1,  32'h0000_0077, 0, 0, 2, 2,  0});
      vecs.push_back('{0, 4'b0101, 4'd8, 32'h5555_0000, 32'h6666_0000, 2'd1, 4,  32'h0000_0088, 0, 0, 0, 5,  0});
      vecs.push_back('{0, 4'b1000, 4'd1, 32'h7777_0000, 32'h0888_0000, 2'd0, 99, 32'hDEAD_BEEF, 0, 2, 3, 52, 1});
      vecs.push_back('{0, 4'b0001, 4'd2, 32'h0999_0000, 32'h0AAA_0000, 2'd3, 51, 32'hCAFE_0051, 1, 0, 0, 52, 0});
      vecs.push_back('{0, 4'b0010, 4'd3, 32'h0BBB_0000, 32'h0CCC_0000, 2'd1, 0,  32'h0000_00EE, 0, 0, 1, 2,  0});
      vecs.push_back('{0, 4'b0110, 4'd4, 32'h0DDD_0000, 32'h0EEE_0000, 2'd2, 52, 32'h1234_5678, 0, 0, 2, 52, 1});
      vecs.push_back('{0, 4'b1001, 4'd5, 32'h0FFF_0000, 32'h0123_0000, 2'd3, 50, 32'h0000_0050, 0, 0, 3, 51, 0});

      repeat (2) @(negedge clk);
      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset during WAIT abandons the operation; a late router done is ignored.
      apply_reset();
      req   = 4'b0001;
      req_a = 128'h0;
      @(negedge clk);
      chk("rw_grant", 32'(grant), 32'h1);
      req = '0;
      repeat (3) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      chk("rw_busy_async", 32'(busy), 32'h0);
      chk("rw_rsp_async", 32'(rsp_valid), 32'h0);
      @(negedge clk);
      reset     = 1'b0;
      m_last    = 3;
      m_ops     = 0;
      m_tos     = 0;
      rt_done   = 1'b1;
      rt_result = 32'hBAD0_BAD0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rw_no_rsp", 32'(rsp_valid), 32'h0);
         chk("rw_op_count", op_count, 32'h0);
         chk("rw_timeout_count", 32'(timeout_count), 32'h0);
         chk("rw_busy", 32'(busy), 32'h0);
      end
      run_txn(4'b0010, 16'h4321, {32'h4, 32'h3, 32'h2, 32'h1}, {32'h8, 32'h7, 32'h6, 32'h5},
              8'b00_01_10_11, 2, 32'h0000_ABCD, 1'b0, 0, 1, 3, 1'b0);

      run_random(150);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
